// File: rtl/axi_dma_rd_master.sv
// axi_dma_rd_master
// Read-DMA master for the DSP memory AXI4 slave. One command (start address,
// beat count) is split into INCR bursts of at most MAX_BURST beats. A burst
// never crosses a 4 KB boundary, and only one burst is in flight at a time.
// Returned beats pass straight through to a valid/ready output stream.

module axi_dma_rd_master #(
    parameter int             A         = 32,
    parameter int             I         = 4,
    parameter int             L         = 8,
    parameter int             D         = 512,
    parameter int             MAX_BURST = 16,
    parameter logic [I-1:0]   RD_ID     = '0
) (
    input  logic             ACLK,
    input  logic             ARESETn,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [A-1:0]     cmd_addr,
    input  logic [15:0]      cmd_len,

    output logic [I-1:0]     ARID,
    output logic [A-1:0]     ARADDR,
    output logic [L-1:0]     ARLEN,
    output logic [2:0]       ARSIZE,
    output logic [1:0]       ARBURST,
    output logic [1:0]       ARLOCK,
    output logic [3:0]       ARCACHE,
    output logic [2:0]       ARPROT,
    output logic             ARVALID,
    input  logic             ARREADY,

    input  logic [I-1:0]     RID,
    input  logic [D-1:0]     RDATA,
    input  logic [1:0]       RRESP,
    input  logic             RLAST,
    input  logic             RVALID,
    output logic             RREADY,

    output logic [D-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done,
    output logic             err
);

    // Bytes per beat and its log2; also the ARSIZE encoding.
    localparam int B  = D / 8;
    localparam int LB = $clog2(B);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]   state;
    logic [A-1:0] cur_addr;
    logic [15:0]  rem;
    logic [L:0]   bcnt;

    logic [12:0]  bnd_bytes;
    logic [16:0]  rem_w;
    logic [16:0]  max_w;
    logic [16:0]  bnd_w;
    logic [16:0]  n_w;
    logic [L:0]   n_beats;
    logic [L:0]   n_m1;
    logic [A-1:0] step;

    logic         in_idle;
    logic         in_addr;
    logic         in_data;
    logic         ar_hs;
    logic         beat;
    logic         last_of_burst;

    // Size of the next burst: the smallest of beats left, the burst cap and
    // the beats remaining before the next 4 KB boundary.
    always_comb begin
        bnd_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
        bnd_w     = {4'd0, bnd_bytes >> LB};
        rem_w     = {1'b0, rem};
        max_w     = 17'(MAX_BURST);
        n_w       = rem_w;
        if (max_w < n_w) begin
            n_w = max_w;
        end
        if (bnd_w < n_w) begin
            n_w = bnd_w;
        end
        n_beats = n_w[L:0];
        n_m1    = n_beats - (L+1)'(1);
        step    = A'(n_beats) << LB;
    end

    assign in_idle       = (state == S_IDLE);
    assign in_addr       = (state == S_ADDR);
    assign in_data       = (state == S_DATA);
    assign ar_hs         = in_addr && ARREADY;
    assign beat          = in_data && RVALID && out_ready;
    assign last_of_burst = (bcnt == (L+1)'(1));

    assign cmd_ready = in_idle;

    assign ARID    = RD_ID;
    assign ARSIZE  = 3'(LB);
    assign ARBURST = 2'b01;
    assign ARLOCK  = 2'b00;
    assign ARCACHE = 4'b0000;
    assign ARPROT  = 3'b000;
    assign ARVALID = in_addr;
    assign ARADDR  = in_addr ? cur_addr : '0;
    assign ARLEN   = in_addr ? n_m1[L-1:0] : '0;

    assign RREADY    = in_data && out_ready;
    assign out_valid = in_data && RVALID;
    assign out_data  = RDATA;
    assign out_last  = in_data && RVALID && last_of_burst && (rem == 16'd0);
    assign done      = (state == S_DONE);

    // Control flow: accept a command, issue a burst, drain it, repeat or finish.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state <= (cmd_len == 16'd0) ? S_DONE : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ARREADY) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat && last_of_burst) begin
                        state <= (rem != 16'd0) ? S_ADDR : S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Next burst address and beats still to request; both advance on the
    // address handshake so the following burst is ready as soon as DATA ends.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cur_addr <= '0;
            rem      <= '0;
        end else if (in_idle && cmd_valid) begin
            cur_addr <= {cmd_addr[A-1:LB], {LB{1'b0}}};
            rem      <= cmd_len;
        end else if (ar_hs) begin
            cur_addr <= cur_addr + step;
            rem      <= rem - n_w[15:0];
        end
    end

    // Beats left in the current burst; this, not RLAST, ends the burst.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bcnt <= '0;
        end else if (ar_hs) begin
            bcnt <= n_beats;
        end else if (beat) begin
            bcnt <= bcnt - (L+1)'(1);
        end
    end

    // Sticky error flag: bad response or RLAST out of step with the count.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err <= 1'b0;
        end else if (in_idle && cmd_valid) begin
            err <= 1'b0;
        end else if (beat && ((RRESP != 2'b00) || (RLAST != last_of_burst))) begin
            err <= 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{RID, cmd_addr[LB-1:0], n_w[16], n_m1[L]};

endmodule
